sync_fifo_level: RTL

//  Single-clock, parametrised FIFO: successor to the team's dual-clock FIFO for same-domain buffering.

---
 rtl/sync_fifo_level_if.sv | 45 ++++
 rtl/sync_fifo_level.sv | 100 ++++++++++
 2 files changed

// File: rtl/sync_fifo_level_if.sv
// rtl/sync_fifo_level_if.sv - producer/consumer bundle for sync_fifo_level
//
// Purpose: groups the write, read and status signals of sync_fifo_level.
// The master modport is the user side, which drives the requests and watches
// the status. The slave modport is the FIFO side.
//   winc, wdata           write request and write data
//   rinc                  read (pop) request
//   rdata, rvalid         read data and read qualifier
//   wfull, rempty         level == DEPTH, level == 0
//   almost_full/empty     threshold flags
//   half                  level >= DEPTH/2
//   level                 occupancy 0..DEPTH
//   write_error/read_error registered rejection pulses
interface sync_fifo_level_if #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16
);
  localparam int AW = $clog2(DEPTH);

  logic                  winc;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  rinc;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  rvalid;
  logic                  wfull;
  logic                  rempty;
  logic                  almost_full;
  logic                  almost_empty;
  logic                  half;
  logic [AW:0]           level;
  logic                  write_error;
  logic                  read_error;

  modport master (
    output winc, wdata, rinc,
    input  rdata, rvalid, wfull, rempty, almost_full, almost_empty, half,
           level, write_error, read_error
  );

  modport slave (
    input  winc, wdata, rinc,
    output rdata, rvalid, wfull, rempty, almost_full, almost_empty, half,
           level, write_error, read_error
  );
endinterface

// File: rtl/sync_fifo_level.sv
// rtl/sync_fifo_level.sv - single-clock FIFO with fill level, threshold flags and error pulses
//
// Purpose: buffers data between a producer and a consumer in the same clock
// domain. Two read styles are available. In the registered style (FWFT=0),
// rdata appears one cycle after a pop. In the fall-through style (FWFT=1),
// the head word is always visible on rdata.
// Ports:
//   clk   rising-edge clock
//   rst   synchronous, active-high reset
//   bus   sync_fifo_level_if.slave, which carries the requests, data, level and flags
module sync_fifo_level #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int FWFT       = 0,
  parameter int AF_THRESH  = 12,
  parameter int AE_THRESH  = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  sync_fifo_level_if.slave        bus
);
  localparam int AW = $clog2(DEPTH);

  if ((DEPTH < 4) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("sync_fifo_level: DEPTH must be a power of 2 and >= 4");
  end
  if ((AF_THRESH < 1) || (AF_THRESH > DEPTH)) begin : g_bad_af
    $error("sync_fifo_level: AF_THRESH out of range");
  end
  if ((AE_THRESH < 0) || (AE_THRESH >= DEPTH)) begin : g_bad_ae
    $error("sync_fifo_level: AE_THRESH out of range");
  end

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW:0]           wptr;
  logic [AW:0]           rptr;
  logic [AW:0]           fill;
  logic                  full;
  logic                  empty;
  logic                  wr_ok;
  logic                  rd_ok;

  // The extra pointer bit tells a full FIFO apart from an empty one. The
  // modulo subtraction therefore gives the occupancy directly.
  assign fill  = wptr - rptr;
  assign full  = (fill == (AW + 1)'(DEPTH));
  assign empty = (fill == '0);
  assign wr_ok = bus.winc & ~full;
  assign rd_ok = bus.rinc & ~empty;

  assign bus.level        = fill;
  assign bus.wfull        = full;
  assign bus.rempty       = empty;
  assign bus.almost_full  = (fill >= (AW + 1)'(AF_THRESH));
  assign bus.almost_empty = (fill <= (AW + 1)'(AE_THRESH));
  assign bus.half         = (fill >= (AW + 1)'(DEPTH / 2));

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr            <= '0;
      rptr            <= '0;
      bus.write_error <= 1'b0;
      bus.read_error  <= 1'b0;
    end else begin
      if (wr_ok) wptr <= wptr + 1'b1;
      if (rd_ok) rptr <= rptr + 1'b1;
      bus.write_error <= bus.winc & full;
      bus.read_error  <= bus.rinc & empty;
    end
  end

  // Storage is not cleared by reset. Writes are still blocked in the reset
  // cycle so that the requests are ignored there.
  always_ff @(posedge clk) begin
    if (!rst && wr_ok) mem[wptr[AW-1:0]] <= bus.wdata;
  end

  if (FWFT != 0) begin : g_fwft
    // The head word is shown while the FIFO holds data. rdata reads 0 when
    // the FIFO is empty, which is also the value it takes after reset.
    assign bus.rdata  = empty ? '0 : mem[rptr[AW-1:0]];
    assign bus.rvalid = ~empty;
  end else begin : g_reg
    logic [DATA_WIDTH-1:0] rdata_q;
    logic                  rvalid_q;

    always_ff @(posedge clk) begin
      if (rst) begin
        rdata_q  <= '0;
        rvalid_q <= 1'b0;
      end else begin
        rvalid_q <= rd_ok;
        if (rd_ok) rdata_q <= mem[rptr[AW-1:0]];
      end
    end

    assign bus.rdata  = rdata_q;
    assign bus.rvalid = rvalid_q;
  end
endmodule
